// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet controller and datapath benches.
package maxnet_pkg;

  // Controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    INIT   = 3'd2,
    MULT   = 3'd3,
    ADD    = 3'd4,
    CHECK  = 3'd5,
    UPDATE = 3'd6,
    DONE   = 3'd7
  } state_t;

  // Activation-input mux selects.
  localparam logic S_INPUT    = 1'b0;
  localparam logic S_FEEDBACK = 1'b1;

endpackage

// File: rtl/maxnet_iter_counter.sv
// Iteration counter: clears on load, increments once per ADD pass and never
// exceeds MAX_ITER; at_max flags that the budget is reached.
module maxnet_iter_counter #(
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned ITER_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [ITER_W-1:0] count,
  output logic              at_max
);

  localparam logic [ITER_W-1:0] LIMIT = ITER_W'(MAX_ITER);

  assign at_max = (count == LIMIT);

  // Count register; clear has priority, increment saturates at LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/maxnet_controller.sv
// Maxnet winner-take-all sequencer: drives datapath strobes/selects through
// load, seed, and repeated multiply/add/check passes until found or timeout.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int unsigned MAX_ITER    = 64,
  parameter int unsigned ITER_W      = 8,
  parameter int unsigned MULT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              found,
  output logic              mainRegWrite,
  output logic              actWrite,
  output logic              multWrite,
  output logic              addWrite,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              s4,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] mult_cnt;
  logic       mult_last;
  logic       at_max;
  logic       sel;
  logic       timeout_set;
  logic       timeout_clr;

  assign mult_last = (mult_cnt == MULT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // MULT hold counter: runs only while in MULT, restarts at 0 on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_cnt <= '0;
    end else if (state == MULT && !mult_last) begin
      mult_cnt <= mult_cnt + 1'b1;
    end else begin
      mult_cnt <= '0;
    end
  end

  // Timeout flag: cleared by an accepted start, set on budget exhaustion,
  // otherwise held so the host can read it after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout <= 1'b0;
    end else if (timeout_clr) begin
      timeout <= 1'b0;
    end else if (timeout_set) begin
      timeout <= 1'b1;
    end
  end

  // Next-state and Moore-decoded strobes/selects.
  always_comb begin
    state_next   = state;
    mainRegWrite = 1'b0;
    actWrite     = 1'b0;
    multWrite    = 1'b0;
    addWrite     = 1'b0;
    sel          = S_INPUT;
    busy         = 1'b1;
    done         = 1'b0;
    timeout_set  = 1'b0;
    timeout_clr  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next  = LOAD;
          timeout_clr = 1'b1;
        end
      end
      LOAD: begin
        mainRegWrite = 1'b1;
        state_next   = INIT;
      end
      INIT: begin
        actWrite   = 1'b1;
        sel        = S_INPUT;
        state_next = MULT;
      end
      MULT: begin
        multWrite = 1'b1;
        if (mult_last) begin
          state_next = ADD;
        end
      end
      ADD: begin
        addWrite   = 1'b1;
        state_next = CHECK;
      end
      CHECK: begin
        if (found) begin
          state_next  = DONE;
          timeout_clr = 1'b1;
        end else if (at_max) begin
          state_next  = DONE;
          timeout_set = 1'b1;
        end else begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        actWrite   = 1'b1;
        sel        = S_FEEDBACK;
        state_next = MULT;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign s1 = sel;
  assign s2 = sel;
  assign s3 = sel;
  assign s4 = sel;

  maxnet_iter_counter #(
    .MAX_ITER (MAX_ITER),
    .ITER_W   (ITER_W)
  ) u_iter_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == LOAD),
    .inc    (state == ADD),
    .count  (iter_count),
    .at_max (at_max)
  );

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: three instances (default, MAX_ITER=3,
// MULT_CYCLES=4) plus a small real-valued Maxnet model driving found.
module tb_maxnet_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: MAX_ITER=64, MULT_CYCLES=1
  logic       start_a = 1'b0, found_a, mrw_a, aw_a, mw_a, adw_a;
  logic       s1_a, s2_a, s3_a, s4_a, busy_a, done_a, to_a;
  logic [7:0] iter_a;
  logic       found_mode = 1'b0; // 0: found tied 1, 1: model
  logic       model_found = 1'b0;
  assign found_a = found_mode ? model_found : 1'b1;

  // Instance B: MAX_ITER=3, found tied 0
  logic       start_b = 1'b0, mrw_b, aw_b, mw_b, adw_b;
  logic       s1_b, s2_b, s3_b, s4_b, busy_b, done_b, to_b;
  logic [7:0] iter_b;

  // Instance C: MULT_CYCLES=4, found tied 1
  logic       start_c = 1'b0, mrw_c, aw_c, mw_c, adw_c;
  logic       s1_c, s2_c, s3_c, s4_c, busy_c, done_c, to_c;
  logic [7:0] iter_c;

  maxnet_controller #(.MAX_ITER(64), .ITER_W(8), .MULT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .found(found_a),
    .mainRegWrite(mrw_a), .actWrite(aw_a), .multWrite(mw_a), .addWrite(adw_a),
    .s1(s1_a), .s2(s2_a), .s3(s3_a), .s4(s4_a),
    .busy(busy_a), .done(done_a), .timeout(to_a), .iter_count(iter_a));

  maxnet_controller #(.MAX_ITER(3), .ITER_W(8), .MULT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .found(1'b0),
    .mainRegWrite(mrw_b), .actWrite(aw_b), .multWrite(mw_b), .addWrite(adw_b),
    .s1(s1_b), .s2(s2_b), .s3(s3_b), .s4(s4_b),
    .busy(busy_b), .done(done_b), .timeout(to_b), .iter_count(iter_b));

  maxnet_controller #(.MAX_ITER(64), .ITER_W(8), .MULT_CYCLES(4)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .found(1'b1),
    .mainRegWrite(mrw_c), .actWrite(aw_c), .multWrite(mw_c), .addWrite(adw_c),
    .s1(s1_c), .s2(s2_c), .s3(s3_c), .s4(s4_c),
    .busy(busy_c), .done(done_c), .timeout(to_c), .iter_count(iter_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Real-valued Maxnet model: a = activations, b = activated outputs.
  real x[4] = '{0.5, 0.3, 0.2, 0.1};
  real eps  = 0.15;
  real a[4] = '{0.0, 0.0, 0.0, 0.0};
  real b[4] = '{0.0, 0.0, 0.0, 0.0};

  function automatic real nb(input int unsigned i);
    real others = 0.0;
    real v;
    for (int unsigned j = 0; j < 4; j++) if (j != i) others += a[j];
    v = a[i] - eps * others;
    return (v > 0.0) ? v : 0.0;
  endfunction

  function automatic int pos_count();
    int n = 0;
    for (int unsigned i = 0; i < 4; i++) if (nb(i) > 0.0) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (aw_a) for (int unsigned i = 0; i < 4; i++) a[i] <= s1_a ? b[i] : x[i];
    if (adw_a) begin
      for (int unsigned i = 0; i < 4; i++) b[i] <= nb(i);
      model_found <= (pos_count() == 1);
    end
  end

  // Strobe exclusivity and select equality on every cycle; pulse counters.
  int done_cnt_a = 0;
  int mrw_cnt_a  = 0;
  always @(negedge clk) begin
    chk("onehot_a", {31'd0, ($countones({mrw_a, aw_a, mw_a, adw_a}) <= 1)}, 1);
    chk("onehot_b", {31'd0, ($countones({mrw_b, aw_b, mw_b, adw_b}) <= 1)}, 1);
    chk("onehot_c", {31'd0, ($countones({mrw_c, aw_c, mw_c, adw_c}) <= 1)}, 1);
    chk("sel_eq_a", {28'd0, s1_a, s2_a, s3_a, s4_a}, {28'd0, {4{s1_a}}});
    if (done_a) done_cnt_a++;
    if (mrw_a)  mrw_cnt_a++;
  end

  int n, adds, upds, mcnt, mfirst, mlast, didx, dc, base;

  initial begin
    // 1: reset state, async reset mid-run
    #1;
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_strobes", {28'd0, mrw_a, aw_a, mw_a, adw_a}, 0);
    chk("rst_iter", {24'd0, iter_a}, 0);
    #1 rst = 1'b0;
    step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    chk("pre_rst_mult", {31'd0, mw_a}, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_outs", {25'd0, mrw_a, aw_a, mw_a, adw_a, busy_a, done_a, to_a}, 0);
    chk("async_rst_iter", {24'd0, iter_a}, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_busy", {31'd0, busy_a}, 0);
    end
    chk("rst_no_done", done_cnt_a, 0);

    // 2: single pass timing, found tied 1
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("t2_load", {30'd0, mrw_a, busy_a}, 3);
    step();
    chk("t2_init", {30'd0, aw_a, s1_a}, 2);
    step();
    chk("t2_mult", {31'd0, mw_a}, 1);
    step();
    chk("t2_add", {31'd0, adw_a}, 1);
    step();
    chk("t2_check", {26'd0, mrw_a, aw_a, mw_a, adw_a, done_a, busy_a}, 1);
    step();
    chk("t2_done", {31'd0, done_a}, 1);
    chk("t2_iter", {24'd0, iter_a}, 1);
    chk("t2_timeout", {31'd0, to_a}, 0);
    step();
    chk("t2_idle", {30'd0, done_a, busy_a}, 0);

    // 3: model datapath, 0.5/0.3/0.2/0.1 with eps 0.15 -> 4 passes
    found_mode = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 200) begin step(); n++; end
    chk("t3_done_seen", {31'd0, done_a}, 1);
    chk("t3_timeout", {31'd0, to_a}, 0);
    chk("t3_iter", {24'd0, iter_a}, 4);
    chk("t3_winner", {31'd0, (b[0] > 0.349 && b[0] < 0.3491 &&
                             b[1] == 0.0 && b[2] == 0.0 && b[3] == 0.0)}, 1);
    found_mode = 1'b0;
    step();

    // 4: timeout with MAX_ITER=3, found tied 0
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    adds = 0; upds = 0; n = 0;
    while (!done_b && n < 100) begin
      if (adw_b) adds++;
      if (aw_b && s1_b) upds++;
      step();
      n++;
    end
    chk("t4_done_seen", {31'd0, done_b}, 1);
    chk("t4_adds", adds, 3);
    chk("t4_updates", upds, 2);
    chk("t4_timeout", {31'd0, to_b}, 1);
    chk("t4_iter", {24'd0, iter_b}, 3);
    step();
    step();
    chk("t4_timeout_held", {31'd0, to_b}, 1);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("t4_timeout_clr", {31'd0, to_b}, 0);
    n = 0;
    while (!done_b && n < 100) begin step(); n++; end
    chk("t4_rerun_done", {31'd0, done_b}, 1);

    // 5: MULT_CYCLES=4
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    mcnt = 0; mfirst = -1; mlast = -1; didx = -1;
    for (int i = 0; i < 30; i++) begin
      if (mw_c) begin
        mcnt++;
        if (mfirst < 0) mfirst = i;
        mlast = i;
      end
      if (done_c) begin didx = i; break; end
      step();
    end
    chk("t5_mult_cycles", mcnt, 4);
    chk("t5_mult_span", mlast - mfirst, 3);
    chk("t5_done_idx", didx, 8);

    // 6: start held through busy and DONE must not restart
    step();
    base = mrw_cnt_a;
    start_a = 1'b1;
    step();
    n = 0;
    while (!done_a && n < 50) begin step(); n++; end
    chk("t6_done_seen", {31'd0, done_a}, 1);
    step();
    start_a = 1'b0;
    chk("t6_no_restart", {31'd0, busy_a}, 0);
    step();
    chk("t6_still_idle", {31'd0, busy_a}, 0);
    chk("t6_one_load", mrw_cnt_a - base, 1);

    // 6: reset during MULT, no done, then a normal run
    dc = done_cnt_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    chk("t6_in_mult", {31'd0, mw_a}, 1);
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    chk("t6_rst_idle", {31'd0, busy_a}, 0);
    step();
    step();
    chk("t6_rst_no_done", done_cnt_a - dc, 0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 50) begin step(); n++; end
    chk("t6_rerun_done", {31'd0, done_a}, 1);
    chk("t6_rerun_iter", {24'd0, iter_a}, 1);
    chk("t6_rerun_timeout", {31'd0, to_a}, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
